uart_apb_sched: RTL

- APB master sequencer that shares the UART APB core between two transmit requesters and one receive consumer.
- After reset it programs the baud divisor. It then loops over three jobs: pending baud reconfiguration, draining received bytes, and writing granted TX bytes once the core reports TX ready.
- Sits between client logic and the UART core's APB slave port.

---
 rtl/uart_apb_sched.sv | 96 +++++++++
 1 files changed

// File: rtl/uart_apb_sched.sv
// uart_apb_sched: APB master sequencing baud setup, RX draining and arbitrated TX writes into one UART core.
module uart_apb_sched #(
  parameter int BITWIDTH = 8,
  parameter logic [BITWIDTH-1:0] BAUD_DEFAULT = 8'd54,
  parameter int POLL_LIMIT = 255
) (
  input  logic                PCLK,
  input  logic                PRESET,
  output logic                m_psel,
  output logic                m_penable,
  output logic [1:0]          m_paddr,
  output logic                m_pwrite,
  output logic [BITWIDTH-1:0] m_pwdata,
  input  logic [BITWIDTH-1:0] m_prdata,
  input  logic                m_pready,
  input  logic                rxrdy_i,
  input  logic                req0_valid,
  input  logic [BITWIDTH-1:0] req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [BITWIDTH-1:0] req1_data,
  output logic                req1_ready,
  input  logic                cfg_baud_we,
  input  logic [BITWIDTH-1:0] cfg_baud,
  output logic                rx_valid,
  output logic [BITWIDTH-1:0] rx_data,
  output logic                busy,
  output logic                timeout_err
);
  localparam int CW = $clog2(POLL_LIMIT + 1);
  typedef enum logic [3:0] {IDLE, CFG_S, CFG_A, RX_S, RX_A, POLL_S, POLL_A, WR_S, WR_A} state_t;
  state_t state, next;
  logic pending, last_grant, take, gnt0, gnt1, last_poll;
  logic [BITWIDTH-1:0] baud_val, wdata;
  logic [CW-1:0] cnt;
  // TX grants only when nothing of higher priority is waiting in IDLE
  assign take = state == IDLE && !PRESET && !pending && !rxrdy_i;
  assign gnt0 = take && req0_valid && (!req1_valid || last_grant);
  assign gnt1 = take && req1_valid && (!req0_valid || !last_grant);
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign last_poll = cnt == CW'(POLL_LIMIT - 1);
  assign m_psel = state != IDLE;
  assign m_penable = state inside {CFG_A, RX_A, POLL_A, WR_A};
  assign m_paddr = state inside {CFG_S, CFG_A} ? 2'd1 : state inside {POLL_S, POLL_A} ? 2'd2 : 2'd0;
  assign m_pwrite = state inside {CFG_S, CFG_A, WR_S, WR_A};
  assign m_pwdata = wdata;
  assign busy = m_psel;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = pending ? CFG_S : rxrdy_i ? RX_S : (gnt0 || gnt1) ? POLL_S : IDLE;
      CFG_S:   next = CFG_A;
      CFG_A:   next = m_pready ? IDLE : CFG_A;
      RX_S:    next = RX_A;
      RX_A:    next = m_pready ? IDLE : RX_A;
      POLL_S:  next = POLL_A;
      POLL_A:  next = !m_pready ? POLL_A : m_prdata[0] ? WR_S : last_poll ? IDLE : POLL_S;
      WR_S:    next = WR_A;
      WR_A:    next = m_pready ? IDLE : WR_A;
      default: next = IDLE;
    endcase
  end
  // pending drops when the write is launched; a later cfg_baud_we re-arms it
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      pending     <= 1'b1;
      baud_val    <= BAUD_DEFAULT;
      last_grant  <= 1'b1;
      cnt         <= '0;
      wdata       <= '0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state    <= next;
      rx_valid <= state == RX_A && m_pready;
      if (state == RX_A && m_pready) rx_data <= m_prdata;
      if (cfg_baud_we) begin
        pending  <= 1'b1;
        baud_val <= cfg_baud;
      end else if (state == IDLE && pending) pending <= 1'b0;
      if (state == IDLE && pending) wdata <= baud_val;
      if (gnt0 || gnt1) begin
        wdata      <= gnt0 ? req0_data : req1_data;
        last_grant <= gnt1;
        cnt        <= '0;
      end
      if (state == POLL_A && m_pready && !m_prdata[0]) begin
        cnt <= cnt + 1'b1;
        if (last_poll) timeout_err <= 1'b1;
      end
    end
  end
endmodule
